// File: rtl/aes_uart_ctrl_if.sv
// Control bundle between the AES-over-UART sequencer and its datapath
// (UART RX/TX, SIPO, AES core, PISO).
interface aes_uart_ctrl_if;
  logic rx_valid;
  logic sipo_shift;
  logic sipo_clr;
  logic aes_start;
  logic aes_done;
  logic piso_load;
  logic piso_shift;
  logic tx_ready;
  logic tx_start;
  logic busy;
  logic blk_done;
  logic timeout;
  logic rx_overrun;

  modport master (
    input  rx_valid, aes_done, tx_ready,
    output sipo_shift, sipo_clr, aes_start, piso_load, piso_shift,
           tx_start, busy, blk_done, timeout, rx_overrun
  );

  modport slave (
    output rx_valid, aes_done, tx_ready,
    input  sipo_shift, sipo_clr, aes_start, piso_load, piso_shift,
           tx_start, busy, blk_done, timeout, rx_overrun
  );
endinterface

// File: rtl/aes_uart_ctrl.sv
// Sequencer for UART RX -> SIPO -> AES -> PISO -> UART TX. Control only:
// counts bytes in, kicks the AES core, then meters result bytes out.
module aes_uart_ctrl #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic          clk,
  input  logic          reset,
  aes_uart_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, AES_START, WAIT_AES, TX_LOAD, TX_SEND, TX_HOLD
  } state_t;

  localparam logic [4:0] LAST_BYTE = 5'(BLOCK_BYTES - 1);
  localparam int TMO_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LIM);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [4:0]       byte_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             rx_open;
  logic             tx_go;

  assign rx_open        = (state == IDLE) || (state == COLLECT);
  assign tx_go          = (state == TX_SEND) && bus.tx_ready;
  assign bus.sipo_shift = bus.rx_valid && rx_open;
  assign bus.tx_start   = tx_go;
  assign bus.piso_shift = tx_go;
  assign bus.blk_done   = tx_go && (byte_cnt == LAST_BYTE);

  // Pulse outputs are set on the transition into their state so they are
  // flops that line up exactly with the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      tmo_cnt        <= '0;
      bus.sipo_clr   <= 1'b0;
      bus.aes_start  <= 1'b0;
      bus.piso_load  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      bus.sipo_clr  <= 1'b0;
      bus.aes_start <= 1'b0;
      bus.piso_load <= 1'b0;
      bus.timeout   <= 1'b0;
      if (bus.rx_valid && !rx_open) bus.rx_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            byte_cnt <= 5'd1;
            tmo_cnt  <= '0;
            state    <= COLLECT;
            bus.busy <= 1'b1;
          end
        end
        COLLECT: begin
          // A byte landing on the expiry edge takes priority over the abort.
          if (bus.rx_valid) begin
            tmo_cnt <= '0;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt      <= '0;
              state         <= AES_START;
              bus.aes_start <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
            end
          end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.sipo_clr <= 1'b1;
            bus.timeout  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        AES_START: state <= WAIT_AES;
        WAIT_AES: begin
          if (bus.aes_done) begin
            state         <= TX_LOAD;
            bus.piso_load <= 1'b1;
          end
        end
        TX_LOAD: begin
          byte_cnt <= '0;
          state    <= TX_SEND;
        end
        TX_SEND: begin
          if (bus.tx_ready) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              state <= TX_HOLD;
            end
          end
        end
        TX_HOLD: begin
          // UART ready lags tx_start by a cycle; skip looking at it here.
          byte_cnt <= byte_cnt + 5'd1;
          state    <= TX_SEND;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Directed bench for aes_uart_ctrl: happy path, TX backpressure, overrun,
// mid-block reset, inter-byte timeout and timeout/byte collision.
module tb_aes_uart_ctrl;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_uart_ctrl_if bus();
  aes_uart_ctrl #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Event monitor: counts and last-seen cycle for every output pulse
  int n_shift = 0, n_aes = 0, n_load = 0, n_tx = 0, n_pshift = 0;
  int n_blk = 0, n_tmo = 0, n_clr = 0, n_viol = 0;
  int last_aes = -1, last_load = -1, last_tx = -1, last_blk = -1;
  int last_tmo = -1, last_clr = -1;
  int last_rx = -1, last_done = -1;
  int s_shift, s_aes, s_load, s_tx, s_pshift, s_blk, s_tmo, s_clr, s_viol;

  // TX backpressure model: ready drops for 50 clocks after each tx_start
  bit tx_ready_base = 1'b1;
  bit bp_mode = 1'b0;
  bit saw_tx = 1'b0;
  int bp_cnt = 0;
  assign bus.tx_ready = bp_mode ? (bp_cnt == 0) : tx_ready_base;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bp_mode && saw_tx) bp_cnt <= 50;
    else if (bp_cnt > 0)   bp_cnt <= bp_cnt - 1;
  end

  always @(negedge clk) begin
    if (bus.sipo_shift) n_shift++;
    if (bus.aes_start)  begin n_aes++;  last_aes  = cyc; end
    if (bus.piso_load)  begin n_load++; last_load = cyc; end
    if (bus.tx_start)   begin n_tx++;   last_tx   = cyc; end
    if (bus.piso_shift) n_pshift++;
    if (bus.blk_done)   begin n_blk++;  last_blk  = cyc; end
    if (bus.timeout)    begin n_tmo++;  last_tmo  = cyc; end
    if (bus.sipo_clr)   begin n_clr++;  last_clr  = cyc; end
    if (bus.tx_start && !bus.tx_ready) n_viol++;
    saw_tx = bus.tx_start;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    s_shift = n_shift; s_aes = n_aes; s_load = n_load; s_tx = n_tx;
    s_pshift = n_pshift; s_blk = n_blk; s_tmo = n_tmo; s_clr = n_clr;
    s_viol = n_viol;
  endtask

  task automatic send_bytes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      last_rx = cyc;
      tick(1);
      bus.rx_valid = 1'b0;
      if (i < n - 1) tick(gap - 1);
    end
  endtask

  // After the 16th byte: wait for aes_start, answer with aes_done 20 clocks
  // later, then wait for blk_done (or for stop_tx bytes when stop_tx > 0).
  task automatic finish_block(input bit ovr, input int stop_tx,
                              output bit ok, output logic ovr_shift);
    int b, t0, k;
    ok = 1'b1;
    ovr_shift = 1'b0;
    b = n_aes; k = 0;
    while (n_aes == b && k < 100) begin tick(1); k++; end
    if (n_aes == b) begin ok = 1'b0; return; end
    if (ovr) begin
      while (cyc < last_aes + 5) tick(1);
      bus.rx_valid = 1'b1;
      #1 ovr_shift = bus.sipo_shift;
      tick(1);
      bus.rx_valid = 1'b0;
    end
    while (cyc < last_aes + 20) tick(1);
    bus.aes_done = 1'b1;
    last_done = cyc;
    tick(1);
    bus.aes_done = 1'b0;
    b = n_blk; t0 = n_tx; k = 0;
    while (n_blk == b && !(stop_tx > 0 && n_tx - t0 >= stop_tx) && k < 3000) begin
      tick(1); k++;
    end
    if (stop_tx > 0) ok = (n_tx - t0 >= stop_tx);
    else begin
      ok = (n_blk != b);
      tick(2);
    end
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    bus.rx_valid = 1'b0; bus.aes_done = 1'b0; tx_ready_base = 1'b1;
    rst = 1'b1;
    tick(3);
    outs = {bus.sipo_shift, bus.sipo_clr, bus.aes_start, bus.piso_load,
            bus.piso_shift, bus.tx_start, bus.busy, bus.blk_done,
            bus.timeout, bus.rx_overrun, 3'b000};
    checks++;
    if (outs !== 13'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    rst = 1'b0;
    tick(2);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_happy();
    bit ok; logic os;
    snap();
    send_bytes(16, 10);
    finish_block(1'b0, 0, ok, os);
    checks++; if (!ok) begin failures++; $display("FAIL happy_done got=0 exp=1"); end
    checks++; if (n_shift - s_shift != 16) begin failures++; $display("FAIL happy_shift got=%0d exp=16", n_shift - s_shift); end
    checks++; if (n_aes - s_aes != 1) begin failures++; $display("FAIL happy_aes got=%0d exp=1", n_aes - s_aes); end
    checks++; if (last_aes != last_rx + 1) begin failures++; $display("FAIL happy_aes_lat got=%0d exp=%0d", last_aes, last_rx + 1); end
    checks++; if (n_load - s_load != 1 || last_load != last_done + 1) begin failures++; $display("FAIL happy_load got=%0d@%0d exp=1@%0d", n_load - s_load, last_load, last_done + 1); end
    checks++; if (n_tx - s_tx != 16) begin failures++; $display("FAIL happy_tx got=%0d exp=16", n_tx - s_tx); end
    // first tx_start 2 clocks after aes_done, then 15 more every 2 clocks
    checks++; if (last_tx != last_done + 32) begin failures++; $display("FAIL happy_tx_spacing got=%0d exp=%0d", last_tx, last_done + 32); end
    checks++; if (n_blk - s_blk != 1 || last_blk != last_tx) begin failures++; $display("FAIL happy_blk got=%0d@%0d exp=1@%0d", n_blk - s_blk, last_blk, last_tx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL happy_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_backpressure();
    bit ok; logic os;
    snap();
    bp_mode = 1'b1;
    send_bytes(16, 3);
    finish_block(1'b0, 0, ok, os);
    bp_mode = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_done got=0 exp=1"); end
    checks++; if (n_tx - s_tx != 16) begin failures++; $display("FAIL bp_tx got=%0d exp=16", n_tx - s_tx); end
    checks++; if (n_pshift - s_pshift != n_tx - s_tx) begin failures++; $display("FAIL bp_pshift got=%0d exp=%0d", n_pshift - s_pshift, n_tx - s_tx); end
    checks++; if (n_viol != s_viol) begin failures++; $display("FAIL bp_tx_while_busy got=%0d exp=0", n_viol - s_viol); end
    checks++; if (n_blk - s_blk != 1) begin failures++; $display("FAIL bp_blk got=%0d exp=1", n_blk - s_blk); end
  endtask

  task automatic test_overrun();
    bit ok; logic os;
    snap();
    send_bytes(16, 2);
    finish_block(1'b1, 0, ok, os);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_done got=0 exp=1"); end
    checks++; if (os !== 1'b0) begin failures++; $display("FAIL ovr_shift got=%b exp=0", os); end
    checks++; if (n_shift - s_shift != 16) begin failures++; $display("FAIL ovr_shift_cnt got=%0d exp=16", n_shift - s_shift); end
    checks++; if (bus.rx_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.rx_overrun); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic os;
    send_bytes(16, 2);
    finish_block(1'b0, 7, ok, os);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_reach7 got=0 exp=1"); end
    tx_ready_base = 1'b0;
    tick(1);
    tx_ready_base = 1'b1;
    #1;
    checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL rmid_in_send got=%b exp=1", bus.tx_start); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.tx_start, bus.piso_shift, bus.blk_done, bus.busy, bus.aes_start,
         bus.piso_load, bus.sipo_clr, bus.timeout, bus.rx_overrun} !== 9'h0) begin
      failures++;
      $display("FAIL rmid_async_outs got=%b%b%b%b exp=0000", bus.tx_start, bus.piso_shift, bus.busy, bus.rx_overrun);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    snap();
    send_bytes(16, 2);
    finish_block(1'b0, 0, ok, os);
    checks++; if (!ok || n_aes - s_aes != 1 || last_aes != last_rx + 1) begin failures++; $display("FAIL rmid_fresh_block got=%0d@%0d exp=1@%0d", n_aes - s_aes, last_aes, last_rx + 1); end
  endtask

  task automatic test_timeout();
    bit ok; logic os;
    int k;
    snap();
    send_bytes(5, 10);
    k = 0;
    while (n_tmo == s_tmo && k < 300) begin tick(1); k++; end
    // byte is sampled one edge after its cycle; abort lands TMO edges later
    checks++; if (n_tmo - s_tmo != 1 || last_tmo != last_rx + 1 + TMO) begin failures++; $display("FAIL tmo_pulse got=%0d@%0d exp=1@%0d", n_tmo - s_tmo, last_tmo, last_rx + 1 + TMO); end
    checks++; if (n_clr - s_clr != 1 || last_clr != last_tmo) begin failures++; $display("FAIL tmo_clr got=%0d@%0d exp=1@%0d", n_clr - s_clr, last_clr, last_tmo); end
    tick(1);
    checks++; if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin failures++; $display("FAIL tmo_idle got=busy%b tmo%b exp=00", bus.busy, bus.timeout); end
    snap();
    send_bytes(16, 10);
    finish_block(1'b0, 0, ok, os);
    checks++; if (!ok || n_tx - s_tx != 16 || last_aes != last_rx + 1) begin failures++; $display("FAIL tmo_next_block got=%0d tx exp=16", n_tx - s_tx); end
  endtask

  task automatic test_collision();
    bit ok; logic os;
    snap();
    send_bytes(5, 10);
    // land the 6th byte on the edge that would otherwise fire the timeout
    tick(TMO - 1);
    send_bytes(1, 1);
    tick(5);
    checks++; if (n_tmo != s_tmo || n_clr != s_clr) begin failures++; $display("FAIL coll_no_tmo got=%0d exp=0", n_tmo - s_tmo); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL coll_busy got=%b exp=1", bus.busy); end
    send_bytes(10, 10);
    finish_block(1'b0, 0, ok, os);
    checks++; if (!ok || n_aes - s_aes != 1 || last_aes != last_rx + 1) begin failures++; $display("FAIL coll_counted got=%0d@%0d exp=1@%0d", n_aes - s_aes, last_aes, last_rx + 1); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.aes_done = 1'b0;
    test_reset();
    test_happy();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_uart_ctrl.md
Name: aes_uart_ctrl

Overview:
- Top-level sequencer for the AES-over-UART path: UART RX bytes -> 128-bit SIPO -> AES core -> PISO -> UART TX.
- Counts received bytes and enables SIPO shifts, starts the AES core once 16 bytes are in, then feeds the 16 result bytes to the UART transmitter one byte at a time.
- Aborts a partial block on an inter-byte timeout.
- Holds no data; it only generates control.

Parameters:
- BLOCK_BYTES, 16: bytes per AES block (RX and TX).
- TIMEOUT_CYCLES, 1000000: idle clocks allowed between bytes while a block is partially received. 0 disables the timeout.
- CNT_W, 20: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  1-cycle pulse from UART RX: a new byte is on the SIPO serial_in
- sipo_shift  out  1  SIPO shift enable (combinational)
- sipo_clr  out  1  SIPO synchronous clear pulse
- aes_start  out  1  1-cycle AES start pulse
- aes_done  in  1  AES result valid (pulse or level; sampled only in WAIT_AES)
- piso_load  out  1  1-cycle parallel load of the AES result into the PISO
- piso_shift  out  1  advance the PISO to its next byte
- tx_ready  in  1  UART TX idle, can accept a byte
- tx_start  out  1  1-cycle pulse: UART TX latches the current PISO byte
- busy  out  1  state != IDLE
- blk_done  out  1  1-cycle pulse after the last TX byte is issued
- timeout  out  1  1-cycle pulse when a partial block is aborted
- rx_overrun  out  1  sticky: a byte arrived while not collecting

Behaviour:
- Reset (asynchronous): state IDLE, byte counter 0, timeout counter 0.
  - All outputs 0, including rx_overrun.
  - Reset asserted mid-block abandons everything. The SIPO contents are don't-care because the next block fully overwrites them.
- Byte counter: 5 bits, range 0..BLOCK_BYTES-1. It is shared by the RX and TX phases and cleared on each phase entry.
- sipo_shift = rx_valid & (state==IDLE | state==COLLECT). Same cycle as rx_valid, no register.
- States and transitions:
  - IDLE: on rx_valid, byte_cnt<=1 and go to COLLECT.
  - COLLECT:
    - On rx_valid: byte_cnt++ and clear the timeout counter.
    - If rx_valid arrives while byte_cnt==BLOCK_BYTES-1: byte_cnt<=0 and go to AES_START.
    - Without rx_valid: the timeout counter increments.
    - When the timeout counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): assert sipo_clr=1 and timeout=1 for one cycle, then go to IDLE.
    - An rx_valid in the same cycle as the timeout wins: the byte counts and the timeout is cancelled.
  - AES_START: aes_start=1 for exactly one cycle, then WAIT_AES.
  - WAIT_AES: stay until aes_done=1, then TX_LOAD. There is no timeout in this state.
  - TX_LOAD: piso_load=1 for one cycle, byte_cnt<=0, then TX_SEND.
  - TX_SEND:
    - If tx_ready: tx_start=1 and piso_shift=1 in the same cycle, then go to TX_HOLD.
    - On the last byte (byte_cnt==BLOCK_BYTES-1): blk_done=1 in that cycle and go to IDLE instead of TX_HOLD.
    - Otherwise wait in TX_SEND.
  - TX_HOLD: exactly one cycle in which tx_ready is ignored. This covers the UART's one-cycle lag in dropping ready. byte_cnt++, then TX_SEND.
- Byte ordering: the first byte received is the MSB byte of the SIPO word. The PISO emits MSB byte first.
- RX lockout: rx_valid in any state other than IDLE/COLLECT is dropped (no sipo_shift) and sets rx_overrun. rx_overrun stays set until reset.
- Timing:
  - Minimum latency from the 16th rx_valid to aes_start is 1 clock.
  - From aes_done to the first tx_start is 2 clocks when tx_ready=1.
- All control outputs are registered Moore decodes of state, except:
  - sipo_shift (combinational from rx_valid);
  - tx_start/piso_shift/blk_done (decoded from state & tx_ready).

Test Plan:
- Happy path:
  - Stimulus: 16 rx_valid pulses carrying bytes 01,23,45,…,10, spaced 10 clocks apart; aes_done pulsed 20 clocks after aes_start; tx_ready held at 1.
  - Response: sipo_shift asserted 16 times, one aes_start pulse, one piso_load, 16 tx_start pulses spaced exactly 2 clocks apart, then a blk_done pulse, busy returns to 0.
- TX backpressure:
  - Stimulus: tx_ready dropped for 50 clocks after each tx_start.
  - Response: tx_start never occurs while tx_ready=0, 16 tx_start pulses total, piso_shift count equals tx_start count.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; send 5 bytes, then nothing.
  - Response: timeout and sipo_clr pulse exactly 100 clocks after the 5th byte. State returns to IDLE. A following 16-byte block then completes normally.
- Overrun:
  - Stimulus: an rx_valid during WAIT_AES.
  - Response: no sipo_shift, rx_overrun=1 and stays 1 through the rest of the block.
- Reset mid-operation:
  - Stimulus: assert reset during TX_SEND after 7 bytes have been sent.
  - Response: all outputs go to 0 immediately (asynchronously), busy=0, and the next rx_valid starts a fresh block with byte_cnt=1.
- Timeout/byte collision:
  - Stimulus: rx_valid arrives on the exact cycle the timeout counter hits TIMEOUT_CYCLES.
  - Response: no timeout pulse, the byte is counted.
